// File: rtl/img_proc_pkg.sv
// Shared types and constants for the Bayer->gray->Sobel frame sequencer.
// Contents: sequencer state encoding, output-stage select, drain/border
// constants and the mode-port decode helper.
package img_proc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SOF = 3'd1,
    ACTIVE   = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    MODE_RAW   = 2'd0,
    MODE_GRAY  = 2'd1,
    MODE_SOBEL = 2'd2
  } out_mode_t;

  // Cycles spent flushing the t+1/t+2 strobe stages after the last pixel
  localparam int unsigned DRAIN_CYCLES = 2;
  // Gray-domain columns/rows at the top/left never produce a full 3x3 window
  localparam int unsigned SOBEL_BORDER = 2;

  // The reserved encoding (3) behaves as Sobel
  function automatic out_mode_t decode_mode(input logic [1:0] m);
    out_mode_t r;
    case (m)
      2'd0:    r = MODE_RAW;
      2'd1:    r = MODE_GRAY;
      default: r = MODE_SOBEL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/img_proc_sequencer_pixel_xy_counter.sv
// Raw pixel position counter for one frame.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   inc        a pixel is accepted this cycle
//   clr        the accepted pixel is a frame start; it is counted as (0,0)
//   x, y       position the next accepted pixel will take
//   last       (x,y) is the final pixel of the frame
module pixel_xy_counter #(
  parameter int unsigned W  = 1280,
  parameter int unsigned H  = 960,
  parameter int unsigned XW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [XW-1:0] x,
  output logic [XW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [XW-1:0] Y_MAX = XW'(H - 1);

  logic [XW-1:0] x_d;
  logic [XW-1:0] y_d;

  // Next position; a frame-start pixel occupies (0,0) so the next one is (1,0)
  always_comb begin
    x_d = x;
    y_d = y;
    if (clr) begin
      x_d = inc ? XW'(1) : '0;
      y_d = '0;
    end else if (inc) begin
      if (x == X_MAX) begin
        x_d = '0;
        y_d = (y == Y_MAX) ? '0 : y + XW'(1);
      end else begin
        x_d = x + XW'(1);
      end
    end
  end

  // Position registers; last is precomputed from the next position
  always_ff @(posedge clk) begin
    if (rst) begin
      x    <= '0;
      y    <= '0;
      last <= 1'b0;
    end else begin
      x    <= x_d;
      y    <= y_d;
      last <= (x_d == X_MAX) && (y_d == Y_MAX);
    end
  end

endmodule

// File: rtl/img_proc_sequencer.sv
// Frame-level controller for the Bayer->gray->Sobel pixel pipeline.
// Tracks raw pixel position, produces the gray/Sobel qualifying strobes,
// selects the SDRAM write strobe and sequences frame start/drain/done.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   enable                 arm capture (looked at in IDLE/DONE only)
//   mode[1:0]              0 raw, 1 gray, 2/3 sobel; latched on accepted SOF
//   cap_valid, cap_sof     raw pixel strobe and frame-start flag
//   lb_clr                 one-cycle line-buffer clear on accepted SOF
//   gray_valid             gray sample complete (t+1)
//   conv_valid             Sobel window full (t+2)
//   out_valid              SDRAM write strobe for the latched mode (t+2)
//   raw_x, raw_y           position of the pixel accepted last cycle
//   busy                   frame in progress (ACTIVE/DRAIN)
//   frame_done             one-cycle end-of-frame pulse
//   err_sof                sticky: SOF seen while a frame was in flight
module img_proc_sequencer
  import img_proc_pkg::*;
#(
  parameter int unsigned IMG_W = 1280,
  parameter int unsigned IMG_H = 960,
  parameter int unsigned XW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic          cap_valid,
  input  logic          cap_sof,
  output logic          lb_clr,
  output logic          gray_valid,
  output logic          conv_valid,
  output logic          out_valid,
  output logic [XW-1:0] raw_x,
  output logic [XW-1:0] raw_y,
  output logic          busy,
  output logic          frame_done,
  output logic          err_sof
);

  localparam logic [2:0] ST_IDLE     = IDLE;
  localparam logic [2:0] ST_WAIT_SOF = WAIT_SOF;
  localparam logic [2:0] ST_ACTIVE   = ACTIVE;
  localparam logic [2:0] ST_DRAIN    = DRAIN;
  localparam logic [2:0] ST_DONE     = DONE;

  localparam int unsigned DCW = 2;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  localparam logic [XW-1:0]  BORDER     = XW'(SOBEL_BORDER);

  logic [2:0]     state, state_d;
  logic [DCW-1:0] drain_cnt, drain_cnt_d;
  out_mode_t      mode_l, mode_l_d;
  out_mode_t      s1_mode, s1_mode_d;
  logic           s1_acc, s1_acc_d;

  logic           lb_clr_d, gray_valid_d, conv_valid_d, out_valid_d;
  logic [XW-1:0]  raw_x_d, raw_y_d;
  logic           busy_d, frame_done_d, err_sof_d;

  logic           accept, sof_acc, restart, last_acc;
  logic [XW-1:0]  cnt_x, cnt_y, pix_x, pix_y;
  logic           cnt_last;

  pixel_xy_counter #(
    .W  (IMG_W),
    .H  (IMG_H),
    .XW (XW)
  ) u_xy (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .clr  (sof_acc),
    .x    (cnt_x),
    .y    (cnt_y),
    .last (cnt_last)
  );

  // Next state, pixel acceptance and next values of every registered output
  always_comb begin
    state_d      = state;
    drain_cnt_d  = drain_cnt;
    mode_l_d     = mode_l;
    s1_mode_d    = s1_mode;
    s1_acc_d     = 1'b0;
    lb_clr_d     = 1'b0;
    gray_valid_d = 1'b0;
    conv_valid_d = 1'b0;
    out_valid_d  = 1'b0;
    raw_x_d      = raw_x;
    raw_y_d      = raw_y;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    err_sof_d    = err_sof;

    // ACTIVE takes every pixel; elsewhere only a SOF pixel (restart in DRAIN/DONE)
    accept   = cap_valid & ((state == ST_ACTIVE) |
                            (cap_sof & ((state == ST_WAIT_SOF) |
                                        (state == ST_DRAIN) |
                                        (state == ST_DONE))));
    sof_acc  = accept & cap_sof;
    restart  = sof_acc & (state != ST_WAIT_SOF);
    last_acc = accept & ~cap_sof & cnt_last;
    pix_x    = sof_acc ? '0 : cnt_x;
    pix_y    = sof_acc ? '0 : cnt_y;

    case (state)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (sof_acc) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (last_acc) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (sof_acc) begin
          state_d = ST_ACTIVE;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt + DCW'(1);
        end
      end
      ST_DONE: begin
        if (sof_acc)     state_d = ST_ACTIVE;
        else if (enable) state_d = ST_WAIT_SOF;
        else             state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (sof_acc) mode_l_d = decode_mode(mode);

    // Stage 1 (t+1): position and gray qualifier; mode travels with the pixel
    s1_acc_d     = accept;
    gray_valid_d = accept & pix_x[0] & pix_y[0];
    lb_clr_d     = sof_acc;
    if (accept) begin
      raw_x_d   = pix_x;
      raw_y_d   = pix_y;
      s1_mode_d = mode_l_d;
    end

    // Stage 2 (t+2): window-full and write-stream select
    conv_valid_d = gray_valid & ((raw_x >> 1) >= BORDER) & ((raw_y >> 1) >= BORDER);
    case (s1_mode)
      MODE_RAW:  out_valid_d = s1_acc;
      MODE_GRAY: out_valid_d = gray_valid;
      default:   out_valid_d = conv_valid_d;
    endcase

    busy_d       = (state_d == ST_ACTIVE) | (state_d == ST_DRAIN);
    frame_done_d = (state_d == ST_DONE);
    err_sof_d    = err_sof | restart;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      mode_l     <= MODE_RAW;
      s1_mode    <= MODE_RAW;
      s1_acc     <= 1'b0;
      lb_clr     <= 1'b0;
      gray_valid <= 1'b0;
      conv_valid <= 1'b0;
      out_valid  <= 1'b0;
      raw_x      <= '0;
      raw_y      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      state      <= state_d;
      drain_cnt  <= drain_cnt_d;
      mode_l     <= mode_l_d;
      s1_mode    <= s1_mode_d;
      s1_acc     <= s1_acc_d;
      lb_clr     <= lb_clr_d;
      gray_valid <= gray_valid_d;
      conv_valid <= conv_valid_d;
      out_valid  <= out_valid_d;
      raw_x      <= raw_x_d;
      raw_y      <= raw_y_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      err_sof    <= err_sof_d;
    end
  end

endmodule

// File: tb/tb_img_proc_sequencer.sv
// Self-checking bench for img_proc_sequencer on an 8x8 frame.
// A bench-side pixel model pushes expected strobe events (with their due
// cycle) into per-strobe queues; a negedge monitor pops and compares them.
module tb_img_proc_sequencer;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned XW = 12;

  logic          clk = 1'b0;
  logic          rst, enable, cap_valid, cap_sof;
  logic [1:0]    mode;
  logic          lb_clr, gray_valid, conv_valid, out_valid;
  logic [XW-1:0] raw_x, raw_y;
  logic          busy, frame_done, err_sof;

  img_proc_sequencer #(.IMG_W(W), .IMG_H(H), .XW(XW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .cap_valid  (cap_valid),
    .cap_sof    (cap_sof),
    .lb_clr     (lb_clr),
    .gray_valid (gray_valid),
    .conv_valid (conv_valid),
    .out_valid  (out_valid),
    .raw_x      (raw_x),
    .raw_y      (raw_y),
    .busy       (busy),
    .frame_done (frame_done),
    .err_sof    (err_sof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int x;
    int y;
  } ev_t;

  // Queue index: 0 lb_clr, 1 gray_valid, 2 conv_valid, 3 out_valid
  ev_t q[4][$];
  int  exp_n[4];
  int  obs_n[4];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  fd_n = 0;
  int  mx = 0, my = 0, mode_l = 0, last_cyc = 0, at = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, got, expv, cyc);
    end
  endtask

  // Scoreboard monitor: overdue entries are misses, pulses must match the queue head
  always @(negedge clk) begin
    logic [3:0] obs;
    ev_t e;
    obs = {out_valid, conv_valid, gray_valid, lb_clr};
    if (frame_done) fd_n++;
    for (int k = 0; k < 4; k++) begin
      while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
        e = q[k].pop_front();
        chk($sformatf("late_strobe%0d", k), cyc, e.cyc);
      end
      if (obs[k]) begin
        obs_n[k]++;
        if (q[k].size() == 0) begin
          chk($sformatf("extra_strobe%0d", k), int'(obs[k]), 0);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("strobe%0d_cyc", k), cyc, e.cyc);
          if (k == 1) begin
            chk("gray_x", int'(raw_x), e.x);
            chk("gray_y", int'(raw_y), e.y);
          end
        end
      end
    end
  end

  // Reference model for one accepted pixel driven in the current cycle
  task automatic push_pix(input bit s);
    ev_t e;
    bit g, cv, ov;
    if (s) begin
      mx = 0; my = 0; mode_l = int'(mode);
      e = '{cyc + 1, 0, 0}; q[0].push_back(e); exp_n[0]++;
    end
    g  = (mx % 2 == 1) && (my % 2 == 1);
    cv = g && (mx / 2 >= 2) && (my / 2 >= 2);
    ov = (mode_l == 0) ? 1'b1 : (mode_l == 1) ? g : cv;
    if (g)  begin e = '{cyc + 1, mx, my}; q[1].push_back(e); exp_n[1]++; end
    if (cv) begin e = '{cyc + 2, mx, my}; q[2].push_back(e); exp_n[2]++; end
    if (ov) begin e = '{cyc + 2, mx, my}; q[3].push_back(e); exp_n[3]++; end
    last_cyc = cyc;
    mx++;
    if (mx == W) begin mx = 0; my = (my + 1) % H; end
  endtask

  task automatic px(input bit v, input bit s, input bit acc);
    cap_valid = v;
    cap_sof   = s;
    if (v && acc) push_pix(s);
    @(posedge clk); #1;
    cap_valid = 1'b0;
    cap_sof   = 1'b0;
  endtask

  task automatic begin_test();
    for (int k = 0; k < 4; k++) begin exp_n[k] = 0; obs_n[k] = 0; end
    fd_n = 0;
  endtask

  task automatic end_test(input string name, input int fd_exp);
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_count%0d", name, k), obs_n[k], exp_n[k]);
    chk($sformatf("%s_frame_done_n", name), fd_n, fd_exp);
  endtask

  // Bounded wait for frame_done; returns -1 on timeout
  task automatic wait_fd(output int fd_at);
    fd_at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) begin fd_at = cyc; break; end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; cap_valid = 1'b0; cap_sof = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", int'({lb_clr, gray_valid, conv_valid, out_valid, busy, frame_done, err_sof}), 0);
    chk("reset_raw_x", int'(raw_x), 0);
    chk("reset_raw_y", int'(raw_y), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: sobel frame, back-to-back pixels
    begin_test();
    mode = 2'd2; enable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) px(1'b1, i == 0, 1'b1);
    @(negedge clk);
    chk("t1_busy_drain", int'(busy), 1);
    wait_fd(at);
    chk("t1_fd_cyc", at, last_cyc + 3);
    chk("t1_busy_done", int'(busy), 0);
    end_test("t1", 1);
    chk("t1_lb_n", obs_n[0], 1);
    chk("t1_gray_n", obs_n[1], 16);
    chk("t1_conv_n", obs_n[2], 4);
    chk("t1_out_n", obs_n[3], 4);

    // 2: raw frame with 50% cap_valid duty, position walk
    begin_test();
    mode = 2'd0;
    for (int i = 0; i < 64; i++) begin
      px(1'b1, i == 0, 1'b1);
      @(negedge clk);
      chk("t2_raw_x", int'(raw_x), i % 8);
      chk("t2_raw_y", int'(raw_y), i / 8);
      px(1'b0, 1'b0, 1'b0);
    end
    wait_fd(at);
    chk("t2_fd_cyc", at, last_cyc + 3);
    end_test("t2", 1);
    chk("t2_out_n", obs_n[3], 64);

    // 3: pixels without SOF are dropped, then a gray frame
    begin_test();
    mode = 2'd1;
    for (int i = 0; i < 5; i++) px(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_hold_x", int'(raw_x), 7);
    chk("t3_hold_y", int'(raw_y), 7);
    chk("t3_busy", int'(busy), 0);
    for (int i = 0; i < 64; i++) px(1'b1, i == 0, 1'b1);
    wait_fd(at);
    chk("t3_fd_cyc", at, last_cyc + 3);
    end_test("t3", 1);
    chk("t3_out_n", obs_n[3], 16);

    // 4: SOF at pixel 20 restarts the frame and sets the sticky error
    begin_test();
    mode = 2'd2;
    chk("t4_err_before", int'(err_sof), 0);
    for (int i = 0; i < 21; i++) px(1'b1, i == 0 || i == 20, 1'b1);
    @(negedge clk);
    chk("t4_err_set", int'(err_sof), 1);
    for (int i = 0; i < 63; i++) px(1'b1, 1'b0, 1'b1);
    wait_fd(at);
    chk("t4_fd_cyc", at, last_cyc + 3);
    end_test("t4", 1);
    chk("t4_lb_n", obs_n[0], 2);
    chk("t4_conv_n", obs_n[2], 4);
    chk("t4_err_sticky", int'(err_sof), 1);

    // 5: enable dropped mid-frame, frame completes, then SOF ignored in IDLE
    begin_test();
    mode = 2'd0;
    for (int i = 0; i < 64; i++) begin
      if (i == 30) enable = 1'b0;
      px(1'b1, i == 0, 1'b1);
    end
    wait_fd(at);
    chk("t5_fd_cyc", at, last_cyc + 3);
    end_test("t5", 1);
    begin_test();
    px(1'b1, 1'b1, 1'b0);
    px(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_idle_busy", int'(busy), 0);
    end_test("t5_idle", 0);
    chk("t5_idle_lb_n", obs_n[0], 0);

    // 6: reset mid-frame, then reserved mode behaves as sobel
    begin_test();
    enable = 1'b1; mode = 2'd2;
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) px(1'b1, i == 0, 1'b1);
    @(negedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) q[k].delete();
    @(negedge clk);
    chk("t6_rst_flags", int'({lb_clr, gray_valid, conv_valid, out_valid, busy, frame_done, err_sof}), 0);
    chk("t6_rst_raw_x", int'(raw_x), 0);
    chk("t6_rst_raw_y", int'(raw_y), 0);
    enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    begin_test();
    px(1'b1, 1'b1, 1'b0);
    end_test("t6_idle", 0);
    begin_test();
    mode = 2'd3; enable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) px(1'b1, i == 0, 1'b1);
    wait_fd(at);
    chk("t6_fd_cyc", at, last_cyc + 3);
    end_test("t6", 1);
    chk("t6_out_n", obs_n[3], 4);
    chk("t6_conv_n", obs_n[2], 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
